// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DRAIN,
        STOP
    } ifu_state_e;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    // PC field is sized for the widest supported XLEN; narrower cores zero-extend.
    localparam int unsigned PC_MAX_W = 64;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [31:0]         data;
        logic                fault;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// Synchronous FIFO with flush; head is read straight from storage.
module ifu_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (count != FULL);
    assign do_rd   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr && rst && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Decoupled instruction fetch: one outstanding memory request, prefetch queue,
// redirect/flush, ebreak halt and access-fault reporting.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst_data,
    output logic            inst_fault,
    output logic            halt
);

    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam int unsigned EW   = $bits(ifu_entry_t);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   q_count;
    logic            req_hs;
    logic            enq;
    logic            deq;
    ifu_entry_t      enq_entry;
    ifu_entry_t      head;

    assign imem_req_valid = rst && (state_q == REQ) && (q_count < FULL);
    assign imem_req_addr  = rst ? fetch_pc_q : RESET_PC;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign inst_valid = rst && (q_count != '0);
    assign deq        = inst_valid && inst_ready;
    assign inst_pc    = XLEN'(head.pc);
    assign inst_data  = head.data;
    assign inst_fault = head.fault;
    assign halt       = deq && !head.fault && (head.data == EBREAK_INSN);

    // fetch_pc has already advanced past the outstanding request
    assign enq_entry.pc    = PC_MAX_W'(fetch_pc_q - XLEN'(4));
    assign enq_entry.data  = imem_rsp_err ? '0 : imem_rsp_data;
    assign enq_entry.fault = imem_rsp_err;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        enq        = 1'b0;
        case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    state_d = req_hs ? DRAIN : REQ;
                end else if (req_hs) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? REQ : DRAIN;
                end else if (imem_rsp_valid) begin
                    enq = 1'b1;
                    if (imem_rsp_err || (imem_rsp_data == EBREAK_INSN)) begin
                        state_d = STOP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            DRAIN: begin
                // A redirect coinciding with the stale response leaves nothing
                // in flight, so leave DRAIN rather than wait forever.
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            STOP: begin
                if (redirect_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ifu_queue #(
        .DEPTH(DEPTH),
        .WIDTH(EW)
    ) u_queue (
        .clk    (clk),
        .rst    (rst),
        .flush  (redirect_valid),
        .wr_en  (enq),
        .wr_data(enq_entry),
        .rd_en  (deq),
        .rd_data(head),
        .count  (q_count)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: transaction-level reference model,
// behavioural memory and directed scenarios with literal expectations.
module tb_ifu_prefetch;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] EBRK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_fault;
    logic        halt;

    ifu_prefetch #(
        .XLEN    (32),
        .RESET_PC(RST_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_pc       (inst_pc),
        .inst_data     (inst_data),
        .inst_fault    (inst_fault),
        .halt          (halt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural instruction memory ----------------
    int          mem_lat     = 1;
    logic [31:0] ebreak_addr = 32'h1;
    logic [31:0] err_addr    = 32'h1;
    logic        hs_seen     = 1'b0;
    logic [31:0] hs_addr     = '0;
    int          mcnt        = 0;
    logic [31:0] maddr       = '0;

    task automatic respond(input logic [31:0] a);
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = (a == err_addr);
        if (a == err_addr)         imem_rsp_data = 32'hDEAD_BEEF;
        else if (a == ebreak_addr) imem_rsp_data = EBRK;
        else                       imem_rsp_data = {a[15:0], 16'h0013};
    endtask

    always @(negedge clk) begin
        hs_seen = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
    end

    always @(posedge clk) begin
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) respond(maddr);
        end
        if (hs_seen) begin
            maddr = hs_addr;
            mcnt  = mem_lat - 1;
            if (mcnt == 0) respond(hs_addr);
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_addr  = '0;
    logic        m_out   = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_stop  = 1'b0;
    logic        exp_rv, exp_halt, req_hs_m, deq_m;

    logic [31:0] req_log[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_data[$];
    logic        del_fault[$];
    int          del_cyc[$];
    int          halt_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_inst_valid", inst_valid, 0);
            chk("rst_halt", halt, 0);
            chk("rst_req_addr", imem_req_addr, RST_PC);
            mq.delete();
            m_pc = RST_PC; m_out = 1'b0; m_stale = 1'b0; m_stop = 1'b0;
        end else begin
            exp_rv = !m_stop && !m_out && (mq.size() < DEPTH);
            chk("req_valid", imem_req_valid, exp_rv);
            if (imem_req_valid) chk("req_addr", imem_req_addr, m_pc);
            chk("inst_valid", inst_valid, mq.size() != 0);
            if (inst_valid && mq.size() != 0) begin
                chk("inst_pc", inst_pc, mq[0].pc);
                chk("inst_data", inst_data, mq[0].data);
                chk("inst_fault", inst_fault, mq[0].fault);
            end
            exp_halt = inst_valid && inst_ready && mq.size() != 0 &&
                       mq[0].data == EBRK && !mq[0].fault;
            chk("halt", halt, exp_halt);

            req_hs_m = imem_req_valid && imem_req_ready;
            deq_m    = inst_valid && inst_ready;
            if (req_hs_m) req_log.push_back(imem_req_addr);
            if (deq_m) begin
                del_pc.push_back(inst_pc);
                del_data.push_back(inst_data);
                del_fault.push_back(inst_fault);
                del_cyc.push_back(cyc);
            end
            if (halt) halt_cyc.push_back(cyc);

            if (deq_m && mq.size() != 0) void'(mq.pop_front());
            if (redirect_valid) begin
                mq.delete();
                m_pc   = redirect_pc & ~32'h3;
                m_stop = 1'b0;
                if (m_out) begin
                    if (imem_rsp_valid) m_out = 1'b0;
                    else                m_stale = 1'b1;
                end
                if (req_hs_m) begin
                    m_out = 1'b1; m_stale = 1'b1;
                end
            end else begin
                if (m_out && imem_rsp_valid) begin
                    m_out = 1'b0;
                    if (!m_stale) begin
                        mq.push_back('{pc: m_addr,
                                       data: imem_rsp_err ? 32'h0 : imem_rsp_data,
                                       fault: imem_rsp_err});
                        if (imem_rsp_err || imem_rsp_data == EBRK) m_stop = 1'b1;
                    end
                    m_stale = 1'b0;
                end
                if (req_hs_m) begin
                    m_out = 1'b1; m_stale = 1'b0; m_addr = m_pc; m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        req_log.delete(); del_pc.delete(); del_data.delete();
        del_fault.delete(); del_cyc.delete(); halt_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic wait_reqs(input int n);
        int k = 0;
        while (req_log.size() < n && k < 200) begin
            step(1);
            k++;
        end
        chk("wait_req_timeout", req_log.size() >= n, 1);
    endtask

    task automatic wait_dels(input int n);
        int k = 0;
        while (del_pc.size() < n && k < 200) begin
            step(1);
            k++;
        end
        chk("wait_del_timeout", del_pc.size() >= n, 1);
    endtask

    initial begin
        // 1: streaming, one instruction every two cycles
        inst_ready = 1'b1;
        do_reset();
        clear_logs();
        step(12);
        chk("t1_nreq", req_log.size() >= 3, 1);
        chk("t1_ndel", del_pc.size() >= 3, 1);
        if (req_log.size() >= 3 && del_pc.size() >= 3) begin
            chk("t1_req0", req_log[0], 32'h8000_0000);
            chk("t1_req1", req_log[1], 32'h8000_0004);
            chk("t1_req2", req_log[2], 32'h8000_0008);
            chk("t1_del0", del_pc[0], 32'h8000_0000);
            chk("t1_data0", del_data[0], 32'h0000_0013);
            chk("t1_del2", del_pc[2], 32'h8000_0008);
            chk("t1_gap01", del_cyc[1] - del_cyc[0], 2);
            chk("t1_gap12", del_cyc[2] - del_cyc[1], 2);
        end

        // 2: decode stalled, queue fills then fetch resumes
        do_reset();
        inst_ready = 1'b0;
        clear_logs();
        step(20);
        chk("t2_nreq_full", req_log.size(), 4);
        chk("t2_req_idle", imem_req_valid, 0);
        chk("t2_head_pc", inst_pc, RST_PC);
        clear_logs();
        inst_ready = 1'b1;
        wait_reqs(1);
        if (req_log.size() >= 1) chk("t2_resume", req_log[0], 32'h8000_0010);

        // 3: redirect while a request is outstanding
        do_reset();
        inst_ready = 1'b0;
        mem_lat = 3;
        clear_logs();
        wait_reqs(2);
        chk("t3_pre_valid", inst_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        step(1);
        redirect_valid = 1'b0;
        chk("t3_flushed", inst_valid, 0);
        clear_logs();
        wait_reqs(1);
        if (req_log.size() >= 1) chk("t3_new_req", req_log[0], 32'h8000_0100);
        inst_ready = 1'b1;
        wait_dels(1);
        if (del_pc.size() >= 1) chk("t3_first_del", del_pc[0], 32'h8000_0100);
        mem_lat = 1;

        // 4: ebreak stops fetch and pulses halt on consumption
        do_reset();
        ebreak_addr = 32'h8000_0008;
        clear_logs();
        step(20);
        chk("t4_nreq", req_log.size(), 3);
        chk("t4_ndel", del_pc.size(), 3);
        chk("t4_nhalt", halt_cyc.size(), 1);
        if (halt_cyc.size() == 1 && del_cyc.size() == 3)
            chk("t4_halt_cycle", halt_cyc[0], del_cyc[2]);
        ebreak_addr = 32'h1;

        // 5: access fault, then redirect restarts fetch
        do_reset();
        err_addr = 32'h8000_000C;
        clear_logs();
        step(20);
        chk("t5_nreq", req_log.size(), 4);
        chk("t5_ndel", del_pc.size(), 4);
        if (del_pc.size() == 4) begin
            chk("t5_fault_pc", del_pc[3], 32'h8000_000C);
            chk("t5_fault_flag", del_fault[3], 1);
            chk("t5_fault_data", del_data[3], 0);
        end
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        step(1);
        redirect_valid = 1'b0;
        wait_reqs(1);
        if (req_log.size() >= 1) chk("t5_restart", req_log[0], 32'h8000_0200);
        err_addr = 32'h1;

        // 6: reset while waiting; late response must be ignored
        do_reset();
        mem_lat = 2;
        clear_logs();
        step(1);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        clear_logs();
        step(10);
        chk("t6_nreq", req_log.size() >= 1, 1);
        chk("t6_ndel", del_pc.size() >= 2, 1);
        if (req_log.size() >= 1) chk("t6_reissue", req_log[0], 32'h8000_0000);
        if (del_pc.size() >= 2) begin
            chk("t6_del0", del_pc[0], 32'h8000_0000);
            chk("t6_del1", del_pc[1], 32'h8000_0004);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
